pair_sample_fifo: RTL and testbench

// Downstream capture stage for the alternating counter pair (8-bit out_a/out_b).
// On each one-cycle sample strobe, the block snapshots the (a,b) pair into a small FIFO.
// It presents the buffered pairs to a consumer (display/UART stage) over a valid/ready

---
 rtl/pair_sample_fifo.sv | 96 +++++++++
 tb/tb_pair_sample_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pair_sample_fifo.sv
// Capture FIFO for the alternating counter pair: a sample strobe snapshots {a,b}
// into a small show-ahead FIFO drained over valid/ready, with sticky drop accounting.
module pair_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     sample,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    input  logic                     clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    pair_t            mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_count_q, drop_count_d;
    logic [7:0]       drop_base;
    logic             pop, push, drop;
    pair_t            head;

    always_comb begin
        out_valid = (count_q != '0);
        pop       = out_ready & out_valid;
        push      = sample & ((count_q < FULL) | pop);
        drop      = sample & (count_q == FULL) & ~pop;

        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);

        // The clear lands first so a coincident drop still registers as one.
        overflow_d = clear_overflow ? 1'b0 : overflow_q;
        drop_base  = clear_overflow ? 8'd0 : drop_count_q;
        drop_count_d = drop_base;
        if (drop) begin
            overflow_d   = 1'b1;
            drop_count_d = (drop_base == 8'hFF) ? 8'hFF : drop_base + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage needs no reset: the read side is masked while empty.
    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_ptr_q] <= '{a: in_a, b: in_b};
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        out_a      = out_valid ? head.a : '0;
        out_b      = out_valid ? head.b : '0;
        count      = count_q;
        overflow   = overflow_q;
        drop_count = drop_count_q;
    end

endmodule

// File: tb/tb_pair_sample_fifo.sv
// Bench for pair_sample_fifo: directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against a queue-based model.
module tb_pair_sample_fifo;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_a = 8'd0, in_b = 8'd0;
    logic       sample = 1'b0, out_ready = 1'b0, clear_overflow = 1'b0;
    logic       out_valid, overflow;
    logic [7:0] out_a, out_b, drop_count;
    logic [2:0] count;

    pair_sample_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .in_a(in_a), .in_b(in_b), .sample(sample),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .count(count), .overflow(overflow), .drop_count(drop_count),
        .clear_overflow(clear_overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [7:0] a; logic [7:0] b; } pr_t;

    pr_t mq[$];
    int  m_ov, m_dc;
    int  n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov = 0;
        m_dc = 0;
    endtask

    // Next-state of the model from the inputs about to be clocked in.
    task automatic model_step();
        bit p, d;
        p = out_ready && (mq.size() > 0);
        if (p) void'(mq.pop_front());
        d = sample && (mq.size() == DEPTH);
        if (clear_overflow) begin m_ov = 0; m_dc = 0; end
        if (d) begin m_ov = 1; m_dc = (m_dc >= 255) ? 255 : m_dc + 1; end
        else if (sample) mq.push_back('{a: in_a, b: in_b});
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_model(input string tag);
        pr_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        chk({tag, ".valid"}, int'(out_valid), int'(mq.size() > 0));
        chk({tag, ".a"}, int'(out_a), int'(h.a));
        chk({tag, ".b"}, int'(out_b), int'(h.b));
        chk({tag, ".count"}, int'(count), mq.size());
        chk({tag, ".ovf"}, int'(overflow), m_ov);
        chk({tag, ".drops"}, int'(drop_count), m_dc);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, int'(out_valid), 0);
        chk({tag, ".a"}, int'(out_a), 0);
        chk({tag, ".b"}, int'(out_b), 0);
        chk({tag, ".count"}, int'(count), 0);
        chk({tag, ".ovf"}, int'(overflow), 0);
        chk({tag, ".drops"}, int'(drop_count), 0);
    endtask

    task automatic set_in(input bit s, input int a, input int b, input bit r, input bit c);
        sample = s; in_a = 8'(a); in_b = 8'(b); out_ready = r; clear_overflow = c;
    endtask

    typedef struct {
        bit s; int a; int b; bit r; bit c;
        int ev; int ea; int eb; int ec; int eo; int ed;
    } vec_t;

    vec_t vt[16];

    initial begin
        // sample a b rdy clr | valid a b count ovf drops
        vt[0]  = '{1, 3, 250, 0, 0,  1, 3, 250, 1, 0, 0};
        vt[1]  = '{0, 0, 0,   1, 0,  0, 0, 0,   0, 0, 0};
        vt[2]  = '{1, 1, 254, 0, 0,  1, 1, 254, 1, 0, 0};
        vt[3]  = '{1, 2, 253, 0, 0,  1, 1, 254, 2, 0, 0};
        vt[4]  = '{1, 3, 252, 0, 0,  1, 1, 254, 3, 0, 0};
        vt[5]  = '{1, 4, 251, 0, 0,  1, 1, 254, 4, 0, 0};
        vt[6]  = '{1, 5, 5,   0, 0,  1, 1, 254, 4, 1, 1};
        vt[7]  = '{1, 6, 6,   0, 0,  1, 1, 254, 4, 1, 2};
        vt[8]  = '{1, 7, 7,   0, 0,  1, 1, 254, 4, 1, 3};
        vt[9]  = '{0, 0, 0,   0, 1,  1, 1, 254, 4, 0, 0};
        vt[10] = '{1, 9, 9,   1, 0,  1, 2, 253, 4, 0, 0};
        vt[11] = '{0, 0, 0,   1, 0,  1, 3, 252, 3, 0, 0};
        vt[12] = '{0, 0, 0,   1, 0,  1, 4, 251, 2, 0, 0};
        vt[13] = '{0, 0, 0,   1, 0,  1, 9, 9,   1, 0, 0};
        vt[14] = '{0, 0, 0,   1, 0,  0, 0, 0,   0, 0, 0};
        vt[15] = '{0, 0, 0,   1, 0,  0, 0, 0,   0, 0, 0};

        // Reset held while inputs toggle.
        model_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, i + 10, 200 - i, i[0], 0);
            @(posedge clock); #1;
            chk_zero($sformatf("rst%0d", i));
        end
        set_in(0, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk_zero("rst_rel");

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            set_in(vt[i].s, vt[i].a, vt[i].b, vt[i].r, vt[i].c);
            tick();
            chk($sformatf("v%0d.valid", i), int'(out_valid), vt[i].ev);
            chk($sformatf("v%0d.a", i), int'(out_a), vt[i].ea);
            chk($sformatf("v%0d.b", i), int'(out_b), vt[i].eb);
            chk($sformatf("v%0d.count", i), int'(count), vt[i].ec);
            chk($sformatf("v%0d.ovf", i), int'(overflow), vt[i].eo);
            chk($sformatf("v%0d.drops", i), int'(drop_count), vt[i].ed);
        end

        // Clear coinciding with a drop: the drop wins, counter restarts at 1.
        for (int i = 0; i < 6; i++) begin set_in(1, 20 + i, 30 + i, 0, 0); tick(); end
        chk("pre_clr.drops", int'(drop_count), 2);
        set_in(1, 99, 99, 0, 1); tick();
        chk("clr_drop.ovf", int'(overflow), 1);
        chk("clr_drop.drops", int'(drop_count), 1);
        chk_model("clr_drop");

        // Drain, then continuous push/pop across several pointer wraps.
        set_in(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) tick();
        chk_model("drained");
        set_in(1, 100, 155, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            set_in(1, 101 + i, 154 - i, 1, 0); tick();
            chk("wrap.count", int'(count), 1);
            chk("wrap.a", int'(out_a), 101 + i);
            chk("wrap.b", int'(out_b), 154 - i);
        end
        chk_model("wrap");

        // Saturation of the drop counter.
        for (int i = 0; i < 305; i++) begin set_in(1, i, ~i, 0, 0); tick(); end
        chk("sat.drops", int'(drop_count), 255);
        chk_model("sat");

        // Async reset mid-stream takes effect before the next edge.
        set_in(1, 1, 2, 1, 0);
        reset = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tick();
        chk_model("post_rst");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            set_in(1'($urandom_range(0, 99) < 60), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), 1'($urandom_range(0, 99) < 45),
                   1'($urandom_range(0, 99) < 3));
            tick();
            chk_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
